sha3_perm_arbiter: RTL

//  Round-robin arbiter and sequencer sharing one sha3_f_func Keccak-f[1600] core among NREQ clients
//  (tape KDF, commitment hash, challenge hash). Latches the winner's 1600-bit state, drives the core's

---
 rtl/sha3_perm_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sha3_perm_arbiter.sv
// sha3_perm_arbiter: round-robin arbiter and sequencer sharing one Keccak-f[1600]
// core among NREQ clients. It latches the winner's state and drives the core's
// start/end handshake. It returns the permuted state and pulses the winner's done bit.
// Optional feature: define SHA3_ARB_LOCK_EN to let a client keep the core across
// consecutive permutations (req_lock); without it req_lock is ignored.
module sha3_perm_arbiter #(
  parameter int NREQ  = 4,
  parameter int SW    = 1600,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*SW-1:0]   req_state,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [SW-1:0]        rsp_state,
  output logic                 busy,
  output logic [CNT_W-1:0]     perm_count,
  output logic                 core_start,
  output logic [SW-1:0]        core_state_in,
  input  logic [SW-1:0]        core_state_out,
  input  logic                 core_end
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     win;
  logic [NREQ-1:0]   cand;
  logic              any_cand;

`ifdef SHA3_ARB_LOCK_EN
  logic              lock_valid;
  logic [IW-1:0]     lock_owner;
  logic              lock_hold;

  // The lock survives only while its owner keeps both req and req_lock high.
  assign lock_hold = lock_valid & req[lock_owner] & req_lock[lock_owner];
`else
  logic              unused_lock;
  assign unused_lock = ^req_lock;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign any_cand = |cand;

  // Pick the first candidate at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    cand = req;
`ifdef SHA3_ARB_LOCK_EN
    if (lock_hold) cand = onehot(lock_owner);
`endif
    win = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[(int'(rr_ptr) + i) % NREQ]) win = IW'((int'(rr_ptr) + i) % NREQ);
    end
  end

  // Sequencer FSM: capture winner, run the core, report result, wait for end to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      done          <= '0;
      rsp_state     <= '0;
      busy          <= 1'b0;
      perm_count    <= '0;
      core_start    <= 1'b0;
      core_state_in <= '0;
      rr_ptr        <= '0;
      owner         <= '0;
`ifdef SHA3_ARB_LOCK_EN
      lock_valid    <= 1'b0;
      lock_owner    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SHA3_ARB_LOCK_EN
          if (lock_valid && !lock_hold) lock_valid <= 1'b0;
`endif
          if (any_cand) begin
            owner         <= win;
            grant         <= onehot(win);
            core_state_in <= req_state[int'(win)*SW +: SW];
            core_start    <= 1'b1;
            busy          <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (core_end) begin
            rsp_state  <= core_state_out;
            core_start <= 1'b0;
            done       <= onehot(owner);
            perm_count <= sat_inc(perm_count);
            state      <= RESP;
          end
        end
        RESP: begin
          done  <= '0;
          grant <= '0;
          state <= DRAIN;
`ifdef SHA3_ARB_LOCK_EN
          if (req_lock[owner]) begin
            lock_valid <= 1'b1;
            lock_owner <= owner;
          end else begin
            lock_valid <= 1'b0;
            rr_ptr     <= next_ptr(owner);
          end
`else
          rr_ptr <= next_ptr(owner);
`endif
        end
        DRAIN: begin
          // A lingering end from the finished permutation must not be read as a new completion.
          if (!core_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
